// File: rtl/eth_ahb_wrr_arbiter.sv
// Weighted round-robin / fixed-priority arbiter for AHB masters with registered one-hot grant.
// Optional grant watchdog enabled by defining ETH_ARB_TIMEOUT_EN.
module eth_ahb_wrr_arbiter #(
   parameter int NUM_CH      = 4,
   parameter int WEIGHT_W    = 3,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                       module_clk,
   input  logic                       module_rstn,
   input  logic                       r_arb_scheme,
   input  logic [NUM_CH*WEIGHT_W-1:0] r_weight,
   input  logic [NUM_CH-1:0]          ch_req,
   input  logic [NUM_CH-1:0]          ch_done,
   output logic [NUM_CH-1:0]          ch_grant,
   output logic                       grant_valid,
   output logic [$clog2(NUM_CH)-1:0]  grant_id,
   output logic                       grant_finish,
   output logic                       arb_timeout
);

   localparam int IDW = $clog2(NUM_CH);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]          state_q, state_d;
   logic [NUM_CH-1:0]   grant_q, grant_d;
   logic [IDW-1:0]      gid_q, gid_d;
   logic                finish_q, finish_d;
   logic [IDW-1:0]      last_ch_q, last_ch_d;
   logic [WEIGHT_W-1:0] run_cnt_q, run_cnt_d;

   logic [WEIGHT_W-1:0] cur_weight;
   logic [IDW-1:0]      start_ch;
   logic [IDW-1:0]      wrr_win;
   logic                wrr_found;
   logic [IDW-1:0]      fp_win;
   logic [IDW-1:0]      win;
   logic                done_hit;
   logic                timeout_hit;

   assign cur_weight = r_weight[int'(last_ch_q)*WEIGHT_W +: WEIGHT_W];
   assign done_hit   = ch_done[gid_q];

   // Stay on last_ch while its run budget lasts, otherwise move past it.
   always_comb begin
      if (run_cnt_q < cur_weight) begin
         start_ch = last_ch_q;
      end else if (last_ch_q == IDW'(NUM_CH - 1)) begin
         start_ch = '0;
      end else begin
         start_ch = last_ch_q + IDW'(1);
      end
   end

   always_comb begin
      wrr_found = 1'b0;
      wrr_win   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!wrr_found && ch_req[(int'(start_ch) + i) % NUM_CH]) begin
            wrr_found = 1'b1;
            wrr_win   = IDW'((int'(start_ch) + i) % NUM_CH);
         end
      end
   end

   always_comb begin
      fp_win = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_req[i]) fp_win = IDW'(i);
      end
   end

   assign win = r_arb_scheme ? fp_win : wrr_win;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      gid_d     = gid_q;
      finish_d  = 1'b0;
      last_ch_d = last_ch_q;
      run_cnt_d = run_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|ch_req) begin
               state_d      = ST_BUSY;
               grant_d      = '0;
               grant_d[win] = 1'b1;
               gid_d        = win;
               if (!r_arb_scheme) begin
                  last_ch_d = win;
                  if (win == last_ch_q && start_ch == last_ch_q) begin
                     run_cnt_d = run_cnt_q + WEIGHT_W'(1);
                  end else begin
                     run_cnt_d = '0;
                  end
               end
            end
         end
         default: begin
            if (done_hit || timeout_hit) begin
               state_d  = ST_IDLE;
               grant_d  = '0;
               gid_d    = '0;
               finish_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge module_clk or negedge module_rstn) begin
      if (!module_rstn) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         gid_q     <= '0;
         finish_q  <= 1'b0;
         last_ch_q <= IDW'(NUM_CH - 1);
         run_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         gid_q     <= gid_d;
         finish_q  <= finish_d;
         last_ch_q <= last_ch_d;
         run_cnt_q <= run_cnt_d;
      end
   end

`ifdef ETH_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
   logic             timeout_q;

   // Counter holds the number of completed BUSY cycles of the current grant.
   assign timeout_hit = (state_q == ST_BUSY) && !done_hit
                        && (busy_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
   assign busy_cnt_d  = (state_q == ST_BUSY) ? busy_cnt_q + CNT_W'(1) : '0;

   always_ff @(posedge module_clk or negedge module_rstn) begin
      if (!module_rstn) begin
         busy_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         busy_cnt_q <= busy_cnt_d;
         timeout_q  <= timeout_hit;
      end
   end

   assign arb_timeout = timeout_q;
`else
   assign timeout_hit = 1'b0;
   assign arb_timeout = 1'b0;
`endif

   assign ch_grant     = grant_q;
   assign grant_valid  = (state_q == ST_BUSY);
   assign grant_id     = gid_q;
   assign grant_finish = finish_q;

endmodule

// File: tb/tb_eth_ahb_wrr_arbiter.sv
// Directed self-checking bench for eth_ahb_wrr_arbiter (4 channels, 3-bit weights).
module tb_eth_ahb_wrr_arbiter;

   logic        clk;
   logic        rstn;
   logic        r_arb_scheme;
   logic [11:0] r_weight;
   logic [3:0]  ch_req;
   logic [3:0]  ch_done;
   logic [3:0]  ch_grant;
   logic        grant_valid;
   logic [1:0]  grant_id;
   logic        grant_finish;
   logic        arb_timeout;

   int checks;
   int failures;

   eth_ahb_wrr_arbiter #(
      .NUM_CH      (4),
      .WEIGHT_W    (3),
      .TIMEOUT_CYC (16)
   ) u_dut (
      .module_clk   (clk),
      .module_rstn  (rstn),
      .r_arb_scheme (r_arb_scheme),
      .r_weight     (r_weight),
      .ch_req       (ch_req),
      .ch_done      (ch_done),
      .ch_grant     (ch_grant),
      .grant_valid  (grant_valid),
      .grant_id     (grant_id),
      .grant_finish (grant_finish),
      .arb_timeout  (arb_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge in IDLE; waits for the grant, checks it, completes it with ch_done.
   task automatic grant_cycle(input int exp_id);
      int n;
      n = 0;
      while (!grant_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("grant_valid", 32'(grant_valid), 32'd1);
      check_eq("grant_id", 32'(grant_id), 32'(exp_id));
      check_eq("ch_grant", 32'(ch_grant), 32'd1 << exp_id);
      check_eq("finish_low_in_busy", 32'(grant_finish), 32'd0);
      ch_done = 4'b0001 << exp_id;
      @(negedge clk);
      ch_done = 4'b0000;
      check_eq("grant_finish", 32'(grant_finish), 32'd1);
      check_eq("released", 32'({ch_grant, grant_valid}), 32'd0);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rstn         = 1'b0;
      r_arb_scheme = 1'b0;
      r_weight     = '0;
      ch_req       = '0;
      ch_done      = '0;

      // Reset and idle with no requests.
      @(negedge clk);
      check_eq("reset_outputs", 32'({ch_grant, grant_valid, grant_id, grant_finish, arb_timeout}),
               32'd0);
      do_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_eq("idle_outputs",
                  32'({ch_grant, grant_valid, grant_id, grant_finish, arb_timeout}), 32'd0);
      end

      // ch_done while idle is ignored.
      ch_done = 4'b1111;
      @(negedge clk);
      ch_done = 4'b0000;
      @(negedge clk);
      check_eq("idle_done_ignored", 32'({grant_valid, grant_finish}), 32'd0);

      // Plain round robin.
      ch_req = 4'b1111;
      grant_cycle(0);
      grant_cycle(1);
      grant_cycle(2);
      grant_cycle(3);
      grant_cycle(0);
      grant_cycle(1);
      ch_req = 4'b0000;

      // Weight 2 on channel 0.
      do_reset();
      r_weight = 12'b000_000_000_010;
      ch_req   = 4'b0011;
      grant_cycle(0);
      grant_cycle(0);
      grant_cycle(0);
      grant_cycle(1);
      grant_cycle(0);
      grant_cycle(0);
      grant_cycle(0);
      grant_cycle(1);
      ch_req   = 4'b0000;
      r_weight = '0;

      // Lone requester keeps winning.
      ch_req = 4'b0100;
      grant_cycle(2);
      grant_cycle(2);
      grant_cycle(2);
      ch_req = 4'b0000;

      // Fixed priority.
      r_arb_scheme = 1'b1;
      ch_req       = 4'b1010;
      grant_cycle(1);
      grant_cycle(1);
      grant_cycle(1);
      ch_req = 4'b1000;
      grant_cycle(3);
      ch_req = 4'b0000;

      // Grant held across req drop and foreign done.
      ch_req = 4'b0100;
      @(negedge clk);
      check_eq("hold_grant_id", 32'(grant_id), 32'd2);
      ch_req  = 4'b0000;
      ch_done = 4'b0010;
      @(negedge clk);
      ch_done = 4'b0000;
      check_eq("hold_after_foreign_done", 32'({ch_grant, grant_valid, grant_finish}),
               32'b0100_1_0);
`ifdef ETH_ARB_TIMEOUT_EN
      repeat (3) @(negedge clk);
`else
      repeat (20) @(negedge clk);
`endif
      check_eq("hold_long", 32'({ch_grant, grant_valid, arb_timeout}), 32'b0100_1_0);
      ch_done = 4'b0100;
      @(negedge clk);
      ch_done = 4'b0000;
      check_eq("release_finish", 32'({ch_grant, grant_valid, grant_finish}), 32'b0000_0_1);
      @(negedge clk);
      check_eq("finish_one_pulse", 32'(grant_finish), 32'd0);

      // Reset mid-BUSY drops grant asynchronously with no finish.
      ch_req = 4'b0001;
      @(negedge clk);
      check_eq("pre_reset_grant", 32'(grant_valid), 32'd1);
      ch_req = 4'b0000;
      #1 rstn = 1'b0;
      #1 check_eq("async_reset_drop", 32'({ch_grant, grant_valid, grant_finish}), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check_eq("no_finish_after_reset", 32'(grant_finish), 32'd0);

`ifdef ETH_ARB_TIMEOUT_EN
      // Watchdog: grant released after 16 BUSY cycles.
      r_arb_scheme = 1'b0;
      do_reset();
      ch_req = 4'b0011;
      @(negedge clk);
      check_eq("to_grant", 32'(grant_id), 32'd0);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         check_eq("to_held", 32'({grant_valid, arb_timeout}), 32'b1_0);
      end
      @(negedge clk);
      check_eq("to_release", 32'({grant_valid, arb_timeout, grant_finish}), 32'b0_1_1);
      @(negedge clk);
      check_eq("to_next", 32'({grant_valid, grant_id, arb_timeout}), 32'b1_01_0);
      ch_req  = 4'b0000;
      ch_done = 4'b0010;
      @(negedge clk);
      ch_done = 4'b0000;
      check_eq("to_next_done", 32'(grant_finish), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eth_ahb_wrr_arbiter.md
ETH_AHB_WRR_ARBITER -- requirements
Module: eth_ahb_wrr_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of AHB master requesters (2..8).
REQ-002 SHALL have parameter WEIGHT_W, default 3, width of each per-channel weight field.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, watchdog limit in cycles (used only under REQ-031).
REQ-004 SHALL use a single clock and an asynchronous active-low reset, named module_clk and module_rstn.
REQ-005 module_clk  input  1  block clock.
REQ-006 module_rstn  input  1  asynchronous active-low reset.
REQ-007 r_arb_scheme  input  1  0 = weighted round robin (WRR), 1 = fixed priority.
REQ-008 r_weight  input  NUM_CH*WEIGHT_W  per-channel weight; channel c occupies bits [c*WEIGHT_W +: WEIGHT_W].
REQ-009 ch_req  input  NUM_CH  level request per channel, held until granted.
REQ-010 ch_done  input  NUM_CH  one-cycle burst-complete pulse from the granted channel.
REQ-011 ch_grant  output  NUM_CH  registered one-hot grant.
REQ-012 grant_valid  output  1  high while any grant is held.
REQ-013 grant_id  output  clog2(NUM_CH)  index of granted channel; 0 when grant_valid low.
REQ-014 grant_finish  output  1  one-cycle pulse when a grant is released.
REQ-015 arb_timeout  output  1  one-cycle pulse when a grant is forcibly released.

Function
REQ-016 SHALL implement FSM IDLE -> BUSY -> IDLE; IDLE with ch_req != 0 arbitrates and enters BUSY; BUSY exits on ch_done[grant_id] (or timeout).
REQ-017 SHALL assert ch_grant/grant_valid/grant_id exactly one cycle after the IDLE cycle that sampled the winning request; grant is always one-hot or zero.
REQ-018 SHALL hold the grant throughout BUSY even if ch_req of the granted channel drops; no abort path other than REQ-031.
REQ-019 SHALL release the grant in the cycle after ch_done[grant_id], pulse grant_finish in that same cycle, and spend at least one cycle in IDLE before the next grant.
REQ-020 SHALL ignore ch_done bits of non-granted channels and any ch_done while IDLE.
REQ-021 Fixed priority: winner = lowest-index requesting channel; WRR state (last_ch, run_cnt) frozen.
REQ-022 WRR: start = last_ch if run_cnt < weight[last_ch], else (last_ch+1) mod NUM_CH; winner = first requesting channel searching circularly from start.
REQ-023 WRR update on grant: winner==last_ch and start==last_ch -> run_cnt+1; otherwise run_cnt <= 0; last_ch <= winner.
REQ-024 Weight w SHALL yield at most w+1 consecutive grants to a channel while another channel requests; w=0 is plain round robin.
REQ-025 A lone requester SHALL be granted indefinitely; run_cnt SHALL never exceed 2^WEIGHT_W-1.
REQ-026 r_weight and r_arb_scheme SHALL be sampled only in the IDLE arbitration cycle; changes during BUSY take effect at the next arbitration.

Reset
REQ-027 On module_rstn low: state IDLE, ch_grant=0, grant_valid=0, grant_id=0, grant_finish=0, arb_timeout=0.
REQ-028 On reset: last_ch = NUM_CH-1, run_cnt = 0, so the first WRR search starts at channel 0.
REQ-029 Reset asserted mid-BUSY SHALL drop the grant asynchronously without a grant_finish pulse.
REQ-030 Outputs SHALL be fully registered; no combinational path from inputs to outputs.

Configuration
REQ-031 With ETH_ARB_TIMEOUT_EN defined: a BUSY-cycle counter reaching TIMEOUT_CYC without ch_done releases the grant, pulses arb_timeout and grant_finish together, returns to IDLE; WRR state advances as if done.
REQ-032 Without ETH_ARB_TIMEOUT_EN: no counter is built, arb_timeout is tied 0, BUSY waits indefinitely.

Verification
REQ-033 Reset, ch_req=4'b0000 -> all outputs 0, state IDLE for 20 cycles.
REQ-034 WRR, all weights 0, ch_req=4'b1111 held, immediate done each grant -> grant_id sequence 0,1,2,3,0,1; grant_finish once per grant.
REQ-035 WRR, weight[0]=2, others 0, ch_req=4'b0011 held -> grant_id 0,0,0,1,0,0,0,1.
REQ-036 Fixed priority, ch_req=4'b1010 -> grant_id 1 repeatedly; channel 3 never granted until ch_req[1]=0.
REQ-037 Channel 2 granted, ch_req[2] drops, ch_done[1] pulses -> grant held; ch_done[2] -> release next cycle with grant_finish=1.
REQ-038 ETH_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, no ch_done -> grant released after 16 BUSY cycles, arb_timeout=1 one cycle, next requester granted.
